// File: rtl/rice_pkg.sv
// Shared types and constants for the Rice encoder.
//   DATA_W       residual width (fixed at 32)
//   PARAM_W      Rice parameter width (k = 0..31)
//   rice_state_e encoder FSM states
package rice_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned PARAM_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StUnary,
    StStop,
    StLsb
  } rice_state_e;

endpackage

// File: rtl/rice_zigzag.sv
// Combinational zigzag map from a signed residual to an unsigned value:
// x >= 0 -> 2x, x < 0 -> -2x-1.
//   data_i  signed residual
//   uval_o  zigzag-mapped unsigned value
module rice_zigzag
  import rice_pkg::*;
#(
  parameter int unsigned Width = DATA_W
) (
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] uval_o
);

  // (x << 1) ^ (x >>> (Width-1)); the arithmetic shift is just sign replication.
  assign uval_o = {data_i[Width-2:0], 1'b0} ^ {Width{data_i[Width-1]}};

endmodule

// File: rtl/rice_encoder.sv
// Serialising Rice encoder: one signed residual + parameter k per handshake,
// emitted one bit per cycle as q zeros, a stop bit, then k LSBs MSB-first.
//   iClock, iNReset        clock, async active-low reset
//   iValid/oReady          residual handshake (iData, iRiceParam)
//   oBit/oBitValid/oLast   codeword bit stream to the packer
//   iBitReady              packer consumes oBit this cycle
module rice_encoder
  import rice_pkg::*;
(
  input  logic               iClock,
  input  logic               iNReset,
  input  logic               iValid,
  input  logic [DATA_W-1:0]  iData,
  input  logic [PARAM_W-1:0] iRiceParam,
  output logic               oReady,
  output logic               oBit,
  output logic               oBitValid,
  input  logic               iBitReady,
  output logic               oLast
);

  rice_state_e        state_q;
  logic [DATA_W-1:0]  uval_q;
  logic [DATA_W-1:0]  cnt_q;
  logic [PARAM_W-1:0] idx_q;
  logic [PARAM_W-1:0] k_q;

  logic [DATA_W-1:0]  uval;
  logic [DATA_W-1:0]  quot;
  logic [PARAM_W-1:0] lsb_sel;

  rice_zigzag #(
    .Width (DATA_W)
  ) u_zigzag (
    .data_i (iData),
    .uval_o (uval)
  );

  assign quot    = uval >> iRiceParam;
  // Bit of uval_q currently on the wire while in StLsb (k >= 1 there).
  assign lsb_sel = k_q - 5'd1 - idx_q;

  always_ff @(posedge iClock or negedge iNReset) begin
    if (!iNReset) begin
      state_q <= StIdle;
      uval_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      k_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (iValid) begin
            uval_q  <= uval;
            k_q     <= iRiceParam;
            cnt_q   <= quot;
            idx_q   <= '0;
            state_q <= (quot != '0) ? StUnary : StStop;
          end
        end
        StUnary: begin
          if (iBitReady) begin
            cnt_q <= cnt_q - 32'd1;
            if (cnt_q == 32'd1) state_q <= StStop;
          end
        end
        StStop: begin
          if (iBitReady) state_q <= (k_q != '0) ? StLsb : StIdle;
        end
        StLsb: begin
          if (iBitReady) begin
            idx_q <= idx_q + 5'd1;
            if (idx_q == k_q - 5'd1) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode registered state only; no path from iValid/iBitReady.
  always_comb begin
    oReady    = 1'b0;
    oBitValid = 1'b0;
    oBit      = 1'b0;
    oLast     = 1'b0;
    unique case (state_q)
      StIdle:  oReady = 1'b1;
      StUnary: oBitValid = 1'b1;
      StStop: begin
        oBitValid = 1'b1;
        oBit      = 1'b1;
        oLast     = (k_q == '0);
      end
      StLsb: begin
        oBitValid = 1'b1;
        oBit      = uval_q[lsb_sel];
        oLast     = (idx_q == k_q - 5'd1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rice_encoder.sv
module tb_rice_encoder;

  logic        iClock;
  logic        iNReset;
  logic        iValid;
  logic [31:0] iData;
  logic [4:0]  iRiceParam;
  logic        oReady;
  logic        oBit;
  logic        oBitValid;
  logic        iBitReady;
  logic        oLast;

  int ncmp  = 0;
  int nfail = 0;

  rice_encoder dut (
    .iClock     (iClock),
    .iNReset    (iNReset),
    .iValid     (iValid),
    .iData      (iData),
    .iRiceParam (iRiceParam),
    .oReady     (oReady),
    .oBit       (oBit),
    .oBitValid  (oBitValid),
    .iBitReady  (iBitReady),
    .oLast      (oLast)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: codeword built from arithmetic zigzag, quotient and remainder.
  // mode 0: always ready, 1: ready pattern 1,0,0,1,..., 2: random ready.
  task automatic encode(input logic signed [31:0] x, input int k, input int mode);
    longint xl, uv, q;
    bit     exp_bits[$];
    int     got, cyc, len;
    bit     rdy;
    xl = longint'(x);
    uv = (xl >= 0) ? 2 * xl : -2 * xl - 1;
    q  = uv >> k;
    for (longint i = 0; i < q; i++) exp_bits.push_back(1'b0);
    exp_bits.push_back(1'b1);
    for (int j = k - 1; j >= 0; j--) exp_bits.push_back(bit'((uv >> j) & 1));
    len = exp_bits.size();

    @(negedge iClock);
    chk("idle_ready", oReady, 1);
    chk("idle_valid", oBitValid, 0);
    iValid     = 1'b1;
    iData      = x;
    iRiceParam = 5'(k);
    @(negedge iClock);
    // Scramble inputs: they must only be sampled at the accept edge.
    iValid     = 1'b0;
    iData      = $urandom;
    iRiceParam = 5'($urandom_range(0, 31));

    got = 0;
    cyc = 0;
    while (got < len && cyc < len * 4 + 50) begin
      chk("busy_valid", oBitValid, 1);
      chk("busy_ready", oReady, 0);
      chk($sformatf("bit%0d", got), oBit, exp_bits[got]);
      chk($sformatf("last%0d", got), oLast, (got == len - 1));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      iBitReady = rdy;
      @(negedge iClock);
      iBitReady = 1'b0;
      if (rdy) got++;
      cyc++;
    end
    if (got < len) chk("timeout_bits", got, len);
    chk("end_valid", oBitValid, 0);
    chk("end_ready", oReady, 1);
  endtask

  initial begin
    longint u, maxq, qv, lsbs, xr;
    int     k;
    iNReset    = 1'b0;
    iValid     = 1'b0;
    iData      = '0;
    iRiceParam = '0;
    iBitReady  = 1'b0;
    repeat (2) @(negedge iClock);
    chk("rst_ready", oReady, 1);
    chk("rst_valid", oBitValid, 0);
    chk("rst_bit", oBit, 0);
    chk("rst_last", oLast, 0);
    iNReset = 1'b1;

    encode(32'sd0, 0, 0);
    encode(32'sd5, 2, 0);
    encode(-32'sd3, 1, 0);
    encode(-32'sd1, 0, 0);
    encode(32'h8000_0000, 31, 0);
    encode(32'sd5, 2, 1);
    encode(32'sd7, 3, 2);

    // Reset in the middle of a long unary run.
    @(negedge iClock);
    iValid = 1'b1; iData = 32'sd100; iRiceParam = 5'd0;
    @(negedge iClock);
    iValid = 1'b0; iBitReady = 1'b1;
    repeat (3) @(negedge iClock);
    iBitReady = 1'b0;
    chk("mid_valid", oBitValid, 1);
    #2 iNReset = 1'b0;
    #1;
    chk("arst_valid", oBitValid, 0);
    chk("arst_ready", oReady, 1);
    chk("arst_bit", oBit, 0);
    @(negedge iClock);
    iNReset = 1'b1;
    @(negedge iClock);
    chk("post_rst_valid", oBitValid, 0);
    encode(32'sd0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      k    = $urandom_range(0, 31);
      maxq = 64'hFFFF_FFFF >> k;
      if (maxq > 40) maxq = 40;
      qv   = longint'($urandom_range(0, 32'(maxq)));
      lsbs = (k == 0) ? 0 : (longint'($urandom) & ((64'd1 << k) - 1));
      u    = (qv << k) | lsbs;
      xr   = (u % 2 == 0) ? u / 2 : -((u + 1) / 2);
      encode(32'(xr), k, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
